// File: rtl/md_responder_pkg.sv
// Shared CPU definitions for the multiply/divide path: md_op encodings,
// default busy durations and the divide helper used by the HI/LO unit.
package md_responder_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6
    } md_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Returns {remainder, quotient}. Works on magnitudes so that
    // 0x80000000 / -1 wraps to 0x80000000 instead of overflowing.
    function automatic logic [63:0] div_result(input logic [31:0] a,
                                               input logic [31:0] b,
                                               input logic        is_signed);
        logic        neg_a;
        logic        neg_b;
        logic [31:0] mag_a;
        logic [31:0] mag_b;
        logic [31:0] quot;
        logic [31:0] rem;
        neg_a = is_signed & a[31];
        neg_b = is_signed & b[31];
        mag_a = neg_a ? (32'd0 - a) : a;
        mag_b = neg_b ? (32'd0 - b) : b;
        if (mag_b == 32'd0) begin
            mag_b = 32'd1;
        end
        quot = mag_a / mag_b;
        rem  = mag_a % mag_b;
        if (neg_a ^ neg_b) begin
            quot = 32'd0 - quot;
        end
        if (neg_a) begin
            rem = 32'd0 - rem;
        end
        return {rem, quot};
    endfunction

endpackage

// File: rtl/md_responder.sv
// HI/LO multiply-divide unit: results are computed combinationally at start,
// held in pending registers, and committed after a fixed busy period.
module md_responder
    import md_responder_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] load_count;
    logic [31:0]      pend_hi;
    logic [31:0]      pend_lo;
    logic [31:0]      next_hi;
    logic [31:0]      next_lo;
    logic [63:0]      mult_s;
    logic [63:0]      mult_u;
    logic [63:0]      div_hl;
    logic             is_md_op;

    assign is_md_op = (md_op == MD_MULT) || (md_op == MD_MULTU) ||
                      (md_op == MD_DIV)  || (md_op == MD_DIVU);

    // Reset gates start so an op seen during reset is never reported as accepted.
    assign start = is_md_op && !busy && !reset;

    always_comb begin
        mult_s     = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
        mult_u     = {32'd0, rs_data} * {32'd0, rt_data};
        div_hl     = div_result(rs_data, rt_data, md_op == MD_DIV);
        next_hi    = hi;
        next_lo    = lo;
        load_count = CNT_W'(MULT_CYCLES);
        case (md_op)
            MD_MULT:  {next_hi, next_lo} = mult_s;
            MD_MULTU: {next_hi, next_lo} = mult_u;
            MD_DIV, MD_DIVU: begin
                load_count = CNT_W'(DIV_CYCLES);
                // Divide by zero commits the current HI/LO, i.e. leaves them unchanged.
                if (rt_data != 32'd0) begin
                    {next_hi, next_lo} = div_hl;
                end
            end
            default: ;
        endcase
    end

    // NOTE: non-blocking assignments throughout, so every register samples
    // pre-edge values; the async reset also clears the pending registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi      <= '0;
            lo      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            count   <= '0;
            busy    <= 1'b0;
        end else if (busy) begin
            if (count == CNT_W'(1)) begin
                hi    <= pend_hi;
                lo    <= pend_lo;
                count <= '0;
                busy  <= 1'b0;
            end else begin
                count <= count - CNT_W'(1);
            end
        end else if (start) begin
            pend_hi <= next_hi;
            pend_lo <= next_lo;
            count   <= load_count;
            busy    <= 1'b1;
        end else if (md_op == MD_MTHI) begin
            hi <= rs_data;
        end else if (md_op == MD_MTLO) begin
            lo <= rs_data;
        end
    end

endmodule

// File: tb/tb_md_responder.sv
// Directed bench for md_responder: expected HI/LO pairs go into a scoreboard
// queue when an op is issued and are popped when busy falls.
module tb_md_responder;
    import md_responder_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  md_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] sb[$];

    md_responder dut (
        .clk     (clk),
        .reset   (reset),
        .md_op   (md_op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .start   (start),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts remaining busy cycles, checks HI/LO hold, then pops the scoreboard.
    task automatic wait_result(input string tag, input int n_left);
        logic [63:0] old_hl;
        logic [63:0] exp;
        logic        held;
        int          cycles;
        old_hl = {hi, lo};
        held   = 1'b1;
        cycles = 0;
        while (busy && cycles < 200) begin
            if ({hi, lo} !== old_hl) held = 1'b0;
            cycles++;
            tick();
        end
        check({tag, " busy cycles"}, 64'(cycles), 64'(n_left));
        check({tag, " hold"}, {63'd0, held}, 64'd1);
        if (sb.size() == 0) begin
            check({tag, " scoreboard empty"}, 64'd1, 64'd0);
        end else begin
            exp = sb.pop_front();
            check({tag, " hi/lo"}, {hi, lo}, exp);
        end
    endtask

    task automatic run_op(input string tag, input md_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input int n, input logic [63:0] exp);
        md_op   = op;
        rs_data = a;
        rt_data = b;
        #1;
        check({tag, " start"}, {63'd0, start}, 64'd1);
        sb.push_back(exp);
        tick();
        md_op = MD_NONE;
        check({tag, " start drop"}, {63'd0, start}, 64'd0);
        wait_result(tag, n);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset   = 1'b1;
        md_op   = MD_NONE;
        rs_data = '0;
        rt_data = '0;
        repeat (2) tick();
        md_op = MD_MULT;
        #1;
        check("reset start", {63'd0, start}, 64'd0);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset hi/lo", {hi, lo}, 64'd0);
        md_op = MD_NONE;
        reset = 1'b0;
        tick();

        run_op("mult -2*3", MD_MULT, 32'hFFFF_FFFE, 32'd3, MULT_CYCLES_DEF,
               {32'hFFFF_FFFF, 32'hFFFF_FFFA});
        run_op("divu 7/2", MD_DIVU, 32'd7, 32'd2, DIV_CYCLES_DEF, {32'd1, 32'd3});
        run_op("div -7/2", MD_DIV, 32'hFFFF_FFF9, 32'd2, DIV_CYCLES_DEF,
               {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op("div ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_CYCLES_DEF,
               {32'd0, 32'h8000_0000});
        run_op("divu big", MD_DIVU, 32'hFFFF_FFFF, 32'd2, DIV_CYCLES_DEF,
               {32'd1, 32'h7FFF_FFFF});
        run_op("multu big", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULT_CYCLES_DEF,
               {32'hFFFF_FFFE, 32'h0000_0001});

        md_op = 4'd7;
        #1;
        check("op7 start", {63'd0, start}, 64'd0);
        tick();
        check("op7 busy", {63'd0, busy}, 64'd0);

        md_op   = MD_MTHI;
        rs_data = 32'h11;
        tick();
        check("mthi hi", {32'd0, hi}, 64'h11);
        check("mthi busy", {63'd0, busy}, 64'd0);
        md_op   = MD_MTLO;
        rs_data = 32'h22;
        tick();
        md_op = MD_NONE;
        check("mtlo hi/lo", {hi, lo}, {32'h11, 32'h22});

        run_op("div 5/0", MD_DIV, 32'd5, 32'd0, DIV_CYCLES_DEF, {32'h11, 32'h22});

        md_op   = MD_MULTU;
        rs_data = 32'h1_0000;
        rt_data = 32'h1_0000;
        #1;
        check("ignore start", {63'd0, start}, 64'd1);
        sb.push_back({32'd1, 32'd0});
        tick();
        md_op   = MD_MTLO;
        rs_data = 32'hABCD;
        tick();
        md_op   = MD_MULT;
        rs_data = 32'd5;
        rt_data = 32'd5;
        #1;
        check("ignore start busy", {63'd0, start}, 64'd0);
        tick();
        md_op = MD_NONE;
        wait_result("ignore", MULT_CYCLES_DEF - 2);

        md_op   = MD_MULT;
        rs_data = 32'd7;
        rt_data = 32'd7;
        tick();
        md_op = MD_NONE;
        tick();
        tick();
        check("midreset busy before", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        #1;
        check("midreset busy", {63'd0, busy}, 64'd0);
        check("midreset hi/lo", {hi, lo}, 64'd0);
        tick();
        reset = 1'b0;
        repeat (8) tick();
        check("midreset late busy", {63'd0, busy}, 64'd0);
        check("midreset late hi/lo", {hi, lo}, 64'd0);

        md_op   = MD_MULT;
        rs_data = 32'd2;
        rt_data = 32'd3;
        #1;
        check("b2b first start", {63'd0, start}, 64'd1);
        sb.push_back({32'd0, 32'd6});
        tick();
        md_op   = MD_DIVU;
        rs_data = 32'd9;
        rt_data = 32'd4;
        #1;
        check("b2b held start", {63'd0, start}, 64'd0);
        wait_result("b2b mult", MULT_CYCLES_DEF);
        check("b2b second start", {63'd0, start}, 64'd1);
        sb.push_back({32'd1, 32'd2});
        tick();
        md_op = MD_NONE;
        wait_result("b2b divu", DIV_CYCLES_DEF);

        check("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
